// File: rtl/cpu_pkg.sv
// cpu_pkg: shared store-size and store-FSM encodings for the multicycle datapath
package cpu_pkg;
  typedef enum logic [1:0] {
    SZ_ILLEGAL = 2'b00,
    SZ_WORD    = 2'b01,
    SZ_HALF    = 2'b10,
    SZ_BYTE    = 2'b11
  } size_e;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: little-endian insertion of a byte or halfword into a memory word
module store_lane_merge import cpu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           old,
  input  logic [DATA_W-1:0]           wdata,
  input  size_e                       size,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  output logic [DATA_W-1:0]           merged
);
  localparam int LW = $clog2(DATA_W/8);
  logic [DATA_W-1:0] m;
  logic [LW+2:0] sh;
  // lane mask shifted to the byte offset; word replaces, illegal passes the old word
  always_comb begin
    m = size == SZ_BYTE ? DATA_W'(8'hff) : DATA_W'(16'hffff);
    sh = {off, 3'b000};
    merged = size == SZ_WORD ? wdata :
             size == SZ_ILLEGAL ? old :
             (old & ~(m << sh)) | ((wdata & m) << sh);
  end
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: read-modify-write store sequencer with alignment check
module store_merge_unit import cpu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);
  localparam int LW = $clog2(DATA_W/8);
  state_e state, nxt;
  size_e sz_in, size_q;
  logic [LW-1:0] off_q;
  logic [DATA_W-1:0] wdata_q, merge_q;
  logic bad;
  // decode the incoming request and flag anything that must be rejected
  always_comb begin
    sz_in = size_e'(size);
    bad = sz_in == SZ_ILLEGAL || (sz_in == SZ_WORD && addr[LW-1:0] != '0) || (sz_in == SZ_HALF && addr[0]);
  end
  // next-state: sub-word stores read first, rejected requests go straight to DONE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : bad ? DONE : sz_in == SZ_WORD ? WRITE : READ;
      READ:    nxt = mem_ready ? WRITE : READ;
      WRITE:   nxt = mem_ready ? DONE : WRITE;
      default: nxt = IDLE;
    endcase
  end
  // state register with registered busy/done
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
    end
  // capture the request once in IDLE so later input changes are ignored
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_addr <= '0;
      off_q <= '0;
      size_q <= SZ_ILLEGAL;
      wdata_q <= '0;
      misaligned <= 1'b0;
    end else if (state == IDLE && start) begin
      mem_addr <= {addr[ADDR_W-1:LW], {LW{1'b0}}};
      off_q <= addr[LW-1:0];
      size_q <= sz_in;
      wdata_q <= wdata;
      misaligned <= bad;
    end
  // hold the word read back from memory as the merge base
  always_ff @(posedge clk or negedge reset)
    if (!reset) merge_q <= '0;
    else if (state == READ && mem_ready) merge_q <= mem_rdata;
  assign mem_rd = state == READ;
  assign mem_wr = state == WRITE;
  store_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old    (merge_q),
    .wdata  (wdata_q),
    .size   (size_q),
    .off    (off_q),
    .merged (mem_wdata)
  );
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: randomized store requests checked against a byte-level memory model
module tb_store_merge_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0, mem_addr, mem_wdata;
  logic mem_rd, mem_wr, mem_ready = 0, busy, done, misaligned;
  int total = 0, bad = 0;
  int rd_wait = 0, wr_wait = 0, rd_n = 0, wr_n = 0, cnt = 0, prev_kind = 0;
  bit noise = 0;
  logic [31:0] mem_model [int unsigned];

  store_merge_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // memory responder: ready after a programmable number of wait cycles per request
  always @(negedge clk) begin
    int kind;
    kind = mem_rd ? 1 : mem_wr ? 2 : 0;
    if (kind != prev_kind) cnt = 0;
    prev_kind = kind;
    mem_ready = kind == 1 ? cnt >= rd_wait : kind == 2 ? cnt >= wr_wait : noise && $urandom_range(0, 1) == 1;
    mem_rdata = (kind == 1 && mem_model.exists(mem_addr)) ? mem_model[mem_addr] : $urandom;
    cnt++;
  end

  // memory side: count completed handshakes and commit writes
  always @(posedge clk) begin
    if (mem_rd && mem_ready) rd_n++;
    if (mem_wr && mem_ready) begin
      wr_n++;
      mem_model[mem_addr] = mem_wdata;
    end
  end

  function automatic logic [31:0] ref_merge(logic [31:0] old, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    logic [31:0] r = old;
    int o = a % 4;
    int n = sz == 3 ? 1 : 2;
    if (sz == 1) return d;
    for (int b = 0; b < 4; b++)
      if (b >= o && b < o + n) r[8*b +: 8] = d[8*(b-o) +: 8];
    return r;
  endfunction

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input bit glitch, input string nm);
    int cyc, rd0, wr0, exp_cyc, exp_rd, exp_wr;
    logic [31:0] al, old, exp, wd_first;
    bit exp_bad, wd_seen;
    al = a & ~32'h3;
    if (!mem_model.exists(al)) mem_model[al] = $urandom;
    old = mem_model[al];
    exp_bad = sz == 0 || (sz == 1 && a % 4 != 0) || (sz == 2 && a % 2 != 0);
    exp = ref_merge(old, sz, a, d);
    exp_cyc = exp_bad ? 2 : sz == 1 ? 3 + wr_wait : 4 + rd_wait + wr_wait;
    exp_rd = (exp_bad || sz == 1) ? 0 : 1;
    exp_wr = exp_bad ? 0 : 1;
    rd0 = rd_n;
    wr0 = wr_n;
    wd_seen = 0;
    size = sz; addr = a; wdata = d; start = 1;
    cyc = 1;
    @(posedge clk); #1;
    cyc = 2;
    start = 0; size = 2'($urandom); addr = $urandom; wdata = $urandom;
    while (1) begin
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1 (cycle %0d)", nm, busy, cyc); end
      total++;
      if (mem_rd && mem_wr) begin bad++; $display("FAIL %s rd_wr_overlap: got rd=1 wr=1 want exclusive", nm); end
      if (mem_rd || mem_wr) begin
        total++;
        if (mem_addr !== al) begin bad++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, al); end
      end
      if (mem_wr) begin
        if (!wd_seen) begin wd_first = mem_wdata; wd_seen = 1; end
        total++;
        if (mem_wdata !== wd_first) begin bad++; $display("FAIL %s wdata_stable: got %h want %h", nm, mem_wdata, wd_first); end
        total++;
        if (mem_wdata !== exp) begin bad++; $display("FAIL %s mem_wdata: got %h want %h", nm, mem_wdata, exp); end
      end
      if (done || cyc >= 200) break;
      start = glitch && cyc == 2;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s timeout: got done=%b want 1 within 200 cycles", nm, done); end
    total++;
    if (cyc != exp_cyc) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_cyc); end
    total++;
    if (misaligned !== exp_bad) begin bad++; $display("FAIL %s misaligned: got %b want %b", nm, misaligned, exp_bad); end
    total++;
    if (rd_n - rd0 != exp_rd) begin bad++; $display("FAIL %s reads: got %0d want %0d", nm, rd_n - rd0, exp_rd); end
    total++;
    if (wr_n - wr0 != exp_wr) begin bad++; $display("FAIL %s writes: got %0d want %0d", nm, wr_n - wr0, exp_wr); end
    total++;
    if (mem_model[al] !== (exp_bad ? old : exp)) begin bad++; $display("FAIL %s memory: got %h want %h", nm, mem_model[al], exp_bad ? old : exp); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL %s after_done: got busy=%b done=%b want 0 0", nm, busy, done); end
    total++;
    if (misaligned !== exp_bad) begin bad++; $display("FAIL %s misaligned_hold: got %b want %b", nm, misaligned, exp_bad); end
    if (glitch) begin
      repeat (4) begin
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s queued_start: got busy=%b done=%b want 0 0", nm, busy, done); end
      end
      total++;
      if (rd_n - rd0 != exp_rd || wr_n - wr0 != exp_wr) begin
        bad++; $display("FAIL %s extra_access: got rd=%0d wr=%0d want rd=%0d wr=%0d", nm, rd_n - rd0, wr_n - wr0, exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_reset;
    #2 reset = 0;
    #1;
    total++;
    if ({mem_rd, mem_wr, busy, done, misaligned} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {mem_rd, mem_wr, busy, done, misaligned}); end
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_release: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_word;
    rd_wait = 0; wr_wait = 0; noise = 0;
    do_store(2'b01, 32'h100, 32'hDEADBEEF, 0, "word");
  endtask

  task automatic test_byte;
    mem_model[32'h100] = 32'h11223344;
    do_store(2'b11, 32'h103, 32'h000000AB, 0, "byte");
    total++;
    if (mem_model[32'h100] !== 32'hAB223344) begin bad++; $display("FAIL byte_value: got %h want AB223344", mem_model[32'h100]); end
  endtask

  task automatic test_half_wait;
    mem_model[32'h200] = 32'hAAAABBBB;
    rd_wait = 2;
    do_store(2'b10, 32'h202, 32'hFFFF1234, 0, "half_wait");
    rd_wait = 0;
    total++;
    if (mem_model[32'h200] !== 32'h1234BBBB) begin bad++; $display("FAIL half_value: got %h want 1234BBBB", mem_model[32'h200]); end
  endtask

  task automatic test_misaligned;
    do_store(2'b10, 32'h101, 32'h5555AAAA, 0, "mis_half");
    do_store(2'b01, 32'h102, 32'h01234567, 0, "mis_word");
    do_store(2'b00, 32'h104, 32'h89ABCDEF, 0, "mis_illegal");
    do_store(2'b11, 32'h105, 32'h000000C3, 0, "clear_byte");
  endtask

  task automatic test_reset_mid_write;
    int wr0;
    wr_wait = 1000;
    wr0 = wr_n;
    size = 2'b01; addr = 32'h400; wdata = $urandom; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 10 && !mem_wr; i++) begin @(posedge clk); #1; end
    total++;
    if (mem_wr !== 1'b1) begin bad++; $display("FAIL rst_mid reach_write: got mem_wr=%b want 1", mem_wr); end
    repeat (2) @(posedge clk);
    #3 reset = 0;
    #1;
    total++;
    if ({mem_rd, mem_wr, busy, done, misaligned} !== 5'b0) begin bad++; $display("FAIL rst_mid flags: got %b want 00000", {mem_rd, mem_wr, busy, done, misaligned}); end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mid data: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    @(posedge clk); #1;
    reset = 1;
    wr_wait = 0;
    total++;
    if (wr_n != wr0) begin bad++; $display("FAIL rst_mid partial_write: got %0d writes want 0", wr_n - wr0); end
    @(posedge clk); #1;
    do_store(2'b01, 32'h404, 32'hCAFEF00D, 0, "after_reset");
  endtask

  task automatic test_start_while_busy;
    rd_wait = 3; wr_wait = 1;
    do_store(2'b11, 32'h301, $urandom, 1, "busy_start");
    rd_wait = 0; wr_wait = 0;
  endtask

  task automatic test_random;
    noise = 1;
    for (int i = 0; i < 60; i++) begin
      rd_wait = $urandom_range(0, 2);
      wr_wait = $urandom_range(0, 2);
      do_store(2'($urandom_range(0, 3)), 32'h300 + $urandom_range(0, 31), $urandom, 0, "random");
    end
    noise = 0;
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half_wait;
    test_misaligned;
    test_reset_mid_write;
    test_start_while_busy;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
